// File: rtl/sig_cmn_axi_pkg.sv
// ---------------------------------------------------------------------------
// sig_cmn_axi_pkg
// Shared definitions for the AXI read-channel register slice:
//   - default widths for the AR/R payload fields
//   - helper that sizes the outstanding-burst counter
//   - state encoding used by every two-entry skid buffer
// No ports (package).
// ---------------------------------------------------------------------------
package sig_cmn_axi_pkg;

    localparam int AXI_ADDR_WIDTH_DEF      = 52;
    localparam int AXI_RD_ID_WIDTH_DEF     = 8;
    localparam int AXI_DATA_WIDTH_DEF      = 512;
    localparam int AXI_USER_REQ_WIDTH_DEF  = 16;
    localparam int AXI_USER_DATA_WIDTH_DEF = 16;
    localparam int MAX_OUTSTANDING_DEF     = 16;

    // Fixed-width AR fields: len(8) size(3) burst(2) lock(2) cache(4) prot(3) qos(4) region(4)
    localparam int AR_FIXED_BITS = 30;

    // Fixed-width R fields: resp(2) last(1)
    localparam int R_FIXED_BITS = 3;

    // Counter must be able to hold the value MAX itself, hence MAX+1 codes.
    function automatic int outstandingWidth(input int maxOutstanding);
        return $clog2(maxOutstanding + 1);
    endfunction

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/sig_cmn_axi_skid.sv
// ---------------------------------------------------------------------------
// sig_cmn_axi_skid
// Two-entry (main + skid) register slice with full throughput and a
// registered ready toward the source.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       source-side handshake (o_ready is a flop)
//   i_data                payload from the source
//   o_valid/i_ready       sink-side handshake
//   o_data                payload to the sink (always the main entry)
// ---------------------------------------------------------------------------
module sig_cmn_axi_skid
    import sig_cmn_axi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    skid_state_e      r_state;
    skid_state_e      w_nextState;
    logic             r_srcReady;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;

    assign w_accept = i_valid && o_ready;
    assign w_drain  = o_valid && i_ready;

    // State register. Ready toward the source is precomputed from the next
    // state so it never depends combinationally on the sink's ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= SKID_EMPTY;
            r_srcReady <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_srcReady <= (w_nextState != SKID_FULL);
        end
    end

    // Next-state logic. FULL never sees an accept because ready is low there.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) w_nextState = SKID_ONE;
            end
            SKID_ONE: begin
                if (w_accept && !w_drain)      w_nextState = SKID_FULL;
                else if (!w_accept && w_drain) w_nextState = SKID_EMPTY;
            end
            SKID_FULL: begin
                if (w_drain) w_nextState = SKID_ONE;
            end
            default: w_nextState = SKID_EMPTY;
        endcase
    end

    // Outputs. Reset forces both handshake signals low immediately so that
    // nothing can complete in the cycle reset is raised.
    always_comb begin
        o_valid = (r_state != SKID_EMPTY) && !i_rst;
        o_ready = r_srcReady && !i_rst;
        o_data  = r_main;
    end

    // Payload storage, intentionally unreset. The main entry takes fresh
    // data when it is empty or being drained; the skid entry only catches
    // the beat that arrives while the main entry is stalled.
    always_ff @(posedge i_clk) begin
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) r_main <= i_data;
            end
            SKID_ONE: begin
                if (w_accept && w_drain) r_main <= i_data;
                else if (w_accept)       r_skid <= i_data;
            end
            SKID_FULL: begin
                if (w_drain) r_main <= r_skid;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sig_cmn_axi_rd_slice.sv
// ---------------------------------------------------------------------------
// sig_cmn_axi_rd_slice
// AXI read-channel register slice between the simulation side and a
// downstream AXI stage. AR and R each pass through a two-entry skid buffer;
// AR issue is throttled by an outstanding-burst counter.
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   ar*_in, arvalid_in/arready_in     AR request from the sim side
//   ar*_out, arvalid_out/arready_out  AR request to downstream
//   r*_out, rvalid_out/rready_out     R beats from downstream
//   r*_in, rvalid_in/rready_in        R beats to the sim side
//   rd_outstanding                    bursts issued and not yet completed
//   err_underflow                     sticky: rlast seen with none outstanding
// ---------------------------------------------------------------------------
module sig_cmn_axi_rd_slice
    import sig_cmn_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH      = AXI_ADDR_WIDTH_DEF,
    parameter int AXI_RD_ID_WIDTH     = AXI_RD_ID_WIDTH_DEF,
    parameter int AXI_DATA_WIDTH      = AXI_DATA_WIDTH_DEF,
    parameter int AXI_USER_REQ_WIDTH  = AXI_USER_REQ_WIDTH_DEF,
    parameter int AXI_USER_DATA_WIDTH = AXI_USER_DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING     = MAX_OUTSTANDING_DEF
) (
    input  logic                                         aclk,
    input  logic                                         areset,

    input  logic [AXI_RD_ID_WIDTH-1:0]                   arid_in,
    input  logic [AXI_ADDR_WIDTH-1:0]                    araddr_in,
    input  logic [7:0]                                   arlen_in,
    input  logic [2:0]                                   arsize_in,
    input  logic [1:0]                                   arburst_in,
    input  logic [1:0]                                   arlock_in,
    input  logic [3:0]                                   arcache_in,
    input  logic [2:0]                                   arprot_in,
    input  logic [3:0]                                   arqos_in,
    input  logic [3:0]                                   arregion_in,
    input  logic [AXI_USER_REQ_WIDTH-1:0]                aruser_in,
    input  logic                                         arvalid_in,
    output logic                                         arready_in,

    output logic [AXI_RD_ID_WIDTH-1:0]                   arid_out,
    output logic [AXI_ADDR_WIDTH-1:0]                    araddr_out,
    output logic [7:0]                                   arlen_out,
    output logic [2:0]                                   arsize_out,
    output logic [1:0]                                   arburst_out,
    output logic [1:0]                                   arlock_out,
    output logic [3:0]                                   arcache_out,
    output logic [2:0]                                   arprot_out,
    output logic [3:0]                                   arqos_out,
    output logic [3:0]                                   arregion_out,
    output logic [AXI_USER_REQ_WIDTH-1:0]                aruser_out,
    output logic                                         arvalid_out,
    input  logic                                         arready_out,

    input  logic [AXI_DATA_WIDTH-1:0]                    rdata_out,
    input  logic [AXI_RD_ID_WIDTH-1:0]                   rid_out,
    input  logic [1:0]                                   rresp_out,
    input  logic                                         rlast_out,
    input  logic [AXI_USER_DATA_WIDTH-1:0]               ruser_out,
    input  logic                                         rvalid_out,
    output logic                                         rready_out,

    output logic [AXI_DATA_WIDTH-1:0]                    rdata_in,
    output logic [AXI_RD_ID_WIDTH-1:0]                   rid_in,
    output logic [1:0]                                   rresp_in,
    output logic                                         rlast_in,
    output logic [AXI_USER_DATA_WIDTH-1:0]               ruser_in,
    output logic                                         rvalid_in,
    input  logic                                         rready_in,

    output logic [outstandingWidth(MAX_OUTSTANDING)-1:0] rd_outstanding,
    output logic                                         err_underflow
);

    localparam int CNT_W = outstandingWidth(MAX_OUTSTANDING);
    localparam int AR_W  = AXI_RD_ID_WIDTH + AXI_ADDR_WIDTH + AR_FIXED_BITS + AXI_USER_REQ_WIDTH;
    localparam int R_W   = AXI_RD_ID_WIDTH + AXI_DATA_WIDTH + R_FIXED_BITS + AXI_USER_DATA_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [AR_W-1:0]  w_arIn;
    logic [AR_W-1:0]  w_arOut;
    logic [R_W-1:0]   w_rIn;
    logic [R_W-1:0]   w_rOut;
    logic             w_arMainValid;
    logic             w_arCanIssue;
    logic             w_arFire;
    logic             w_rLastFire;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_errUnderflow;

    assign w_arIn = {arid_in, araddr_in, arlen_in, arsize_in, arburst_in, arlock_in,
                     arcache_in, arprot_in, arqos_in, arregion_in, aruser_in};
    assign {arid_out, araddr_out, arlen_out, arsize_out, arburst_out, arlock_out,
            arcache_out, arprot_out, arqos_out, arregion_out, aruser_out} = w_arOut;

    assign w_rIn = {rid_out, rdata_out, rresp_out, rlast_out, ruser_out};
    assign {rid_in, rdata_in, rresp_in, rlast_in, ruser_in} = w_rOut;

    // At the burst limit the AR entry is hidden from downstream and the
    // slice sees no ready, so it simply holds its contents.
    assign w_arCanIssue = (r_outstanding < MAX_CNT);
    assign arvalid_out  = w_arMainValid && w_arCanIssue;

    sig_cmn_axi_skid #(
        .WIDTH (AR_W)
    ) u_arSkid (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_valid (arvalid_in),
        .o_ready (arready_in),
        .i_data  (w_arIn),
        .o_valid (w_arMainValid),
        .i_ready (arready_out && w_arCanIssue),
        .o_data  (w_arOut)
    );

    sig_cmn_axi_skid #(
        .WIDTH (R_W)
    ) u_rSkid (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_valid (rvalid_out),
        .o_ready (rready_out),
        .i_data  (w_rIn),
        .o_valid (rvalid_in),
        .i_ready (rready_in),
        .o_data  (w_rOut)
    );

    assign w_arFire    = arvalid_out && arready_out;
    assign w_rLastFire = rvalid_in && rready_in && rlast_in;

    // Outstanding-burst tracking. An issue and a completion in the same
    // cycle cancel. A completion with nothing outstanding is a protocol
    // error: the count saturates at zero and the sticky flag records it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_outstanding  <= '0;
            r_errUnderflow <= 1'b0;
        end else if (w_arFire && !w_rLastFire) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
        end else if (!w_arFire && w_rLastFire) begin
            if (r_outstanding == '0) r_errUnderflow <= 1'b1;
            else                     r_outstanding  <= r_outstanding - CNT_W'(1);
        end
    end

    assign rd_outstanding = areset ? '0 : r_outstanding;
    assign err_underflow  = r_errUnderflow && !areset;

endmodule

// File: tb/tb_sig_cmn_axi_rd_slice.sv
// ---------------------------------------------------------------------------
// tb_sig_cmn_axi_rd_slice
// Directed bench for the AXI read slice, built with a burst limit of 2 so the
// throttle is reachable with short sequences.
// ---------------------------------------------------------------------------
module tb_sig_cmn_axi_rd_slice;

    localparam int ADDR_W = 52;
    localparam int ID_W   = 8;
    localparam int DATA_W = 512;
    localparam int UREQ_W = 16;
    localparam int UDAT_W = 16;
    localparam int MAXO   = 2;
    localparam int CNT_W  = $clog2(MAXO + 1);

    logic              aclk;
    logic              areset;
    logic [ID_W-1:0]   arid_in;
    logic [ADDR_W-1:0] araddr_in;
    logic [7:0]        arlen_in;
    logic [2:0]        arsize_in;
    logic [1:0]        arburst_in;
    logic [1:0]        arlock_in;
    logic [3:0]        arcache_in;
    logic [2:0]        arprot_in;
    logic [3:0]        arqos_in;
    logic [3:0]        arregion_in;
    logic [UREQ_W-1:0] aruser_in;
    logic              arvalid_in;
    logic              arready_in;
    logic [ID_W-1:0]   arid_out;
    logic [ADDR_W-1:0] araddr_out;
    logic [7:0]        arlen_out;
    logic [2:0]        arsize_out;
    logic [1:0]        arburst_out;
    logic [1:0]        arlock_out;
    logic [3:0]        arcache_out;
    logic [2:0]        arprot_out;
    logic [3:0]        arqos_out;
    logic [3:0]        arregion_out;
    logic [UREQ_W-1:0] aruser_out;
    logic              arvalid_out;
    logic              arready_out;
    logic [DATA_W-1:0] rdata_out;
    logic [ID_W-1:0]   rid_out;
    logic [1:0]        rresp_out;
    logic              rlast_out;
    logic [UDAT_W-1:0] ruser_out;
    logic              rvalid_out;
    logic              rready_out;
    logic [DATA_W-1:0] rdata_in;
    logic [ID_W-1:0]   rid_in;
    logic [1:0]        rresp_in;
    logic              rlast_in;
    logic [UDAT_W-1:0] ruser_in;
    logic              rvalid_in;
    logic              rready_in;
    logic [CNT_W-1:0]  rd_outstanding;
    logic              err_underflow;

    int testsRun;
    int testsFailed;

    sig_cmn_axi_rd_slice #(
        .AXI_ADDR_WIDTH      (ADDR_W),
        .AXI_RD_ID_WIDTH     (ID_W),
        .AXI_DATA_WIDTH      (DATA_W),
        .AXI_USER_REQ_WIDTH  (UREQ_W),
        .AXI_USER_DATA_WIDTH (UDAT_W),
        .MAX_OUTSTANDING     (MAXO)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .arid_in        (arid_in),
        .araddr_in      (araddr_in),
        .arlen_in       (arlen_in),
        .arsize_in      (arsize_in),
        .arburst_in     (arburst_in),
        .arlock_in      (arlock_in),
        .arcache_in     (arcache_in),
        .arprot_in      (arprot_in),
        .arqos_in       (arqos_in),
        .arregion_in    (arregion_in),
        .aruser_in      (aruser_in),
        .arvalid_in     (arvalid_in),
        .arready_in     (arready_in),
        .arid_out       (arid_out),
        .araddr_out     (araddr_out),
        .arlen_out      (arlen_out),
        .arsize_out     (arsize_out),
        .arburst_out    (arburst_out),
        .arlock_out     (arlock_out),
        .arcache_out    (arcache_out),
        .arprot_out     (arprot_out),
        .arqos_out      (arqos_out),
        .arregion_out   (arregion_out),
        .aruser_out     (aruser_out),
        .arvalid_out    (arvalid_out),
        .arready_out    (arready_out),
        .rdata_out      (rdata_out),
        .rid_out        (rid_out),
        .rresp_out      (rresp_out),
        .rlast_out      (rlast_out),
        .ruser_out      (ruser_out),
        .rvalid_out     (rvalid_out),
        .rready_out     (rready_out),
        .rdata_in       (rdata_in),
        .rid_in         (rid_in),
        .rresp_in       (rresp_in),
        .rlast_in       (rlast_in),
        .ruser_in       (ruser_in),
        .rvalid_in      (rvalid_in),
        .rready_in      (rready_in),
        .rd_outstanding (rd_outstanding),
        .err_underflow  (err_underflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One clock step; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive an AR request; user field is derived from the address.
    task automatic applyStimulus(input logic vld, input logic [ADDR_W-1:0] addr,
                                 input logic [7:0] len, input logic [ID_W-1:0] id);
        arvalid_in = vld;
        araddr_in  = addr;
        arlen_in   = len;
        arid_in    = id;
        aruser_in  = addr[15:0] ^ 16'h5a5a;
    endtask

    // Drive an R beat; every field is derived from one 64-bit word.
    task automatic driveR(input logic vld, input logic [63:0] word, input logic last);
        rvalid_out = vld;
        rdata_out  = {8{word}};
        rid_out    = word[7:0];
        rresp_out  = word[1:0];
        ruser_out  = word[15:0];
        rlast_out  = last;
    endtask

    // Complete n single-beat bursts back to back, then let the slice empty.
    task automatic sendRlast(input int n);
        rready_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            driveR(1'b1, 64'hF000 + 64'(i), 1'b1);
            tick();
        end
        driveR(1'b0, 64'h0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        logic [63:0] word;
        testsRun    = 0;
        testsFailed = 0;
        areset      = 1'b1;
        arready_out = 1'b0;
        rready_in   = 1'b0;
        arsize_in   = 3'd6;
        arburst_in  = 2'd1;
        arlock_in   = 2'd0;
        arcache_in  = 4'h3;
        arprot_in   = 3'h2;
        arqos_in    = 4'h1;
        arregion_in = 4'h0;
        applyStimulus(1'b0, '0, 8'd0, 8'd0);
        driveR(1'b0, 64'h0, 1'b0);

        // Reset values
        tick(); tick(); tick();
        checkOutput("rst_arvalid_out", arvalid_out, 0);
        checkOutput("rst_rvalid_in", rvalid_in, 0);
        checkOutput("rst_arready_in", arready_in, 0);
        checkOutput("rst_rready_out", rready_out, 0);
        checkOutput("rst_count", rd_outstanding, 0);
        checkOutput("rst_err", err_underflow, 0);
        areset = 1'b0;
        tick();
        checkOutput("rel_arready_in", arready_in, 1);
        checkOutput("rel_rready_out", rready_out, 1);

        // Single read: AR forwarded one cycle later, four beats, count 0->1->0
        arready_out = 1'b1;
        applyStimulus(1'b1, 52'h1000, 8'd3, 8'd5);
        checkOutput("single_ar_not_early", arvalid_out, 0);
        tick();
        applyStimulus(1'b0, 52'h1000, 8'd3, 8'd5);
        checkOutput("single_arvalid", arvalid_out, 1);
        checkOutput("single_araddr", araddr_out, 52'h1000);
        checkOutput("single_arlen", arlen_out, 3);
        checkOutput("single_arid", arid_out, 5);
        checkOutput("single_aruser", aruser_out, 16'h4a5a);
        checkOutput("single_arsize", arsize_out, 6);
        checkOutput("single_arburst", arburst_out, 1);
        checkOutput("single_arlock", arlock_out, 0);
        checkOutput("single_arcache", arcache_out, 4'h3);
        checkOutput("single_arprot", arprot_out, 3'h2);
        checkOutput("single_arqos", arqos_out, 4'h1);
        checkOutput("single_arregion", arregion_out, 0);
        checkOutput("single_count0", rd_outstanding, 0);
        tick();
        checkOutput("single_count1", rd_outstanding, 1);
        checkOutput("single_ar_done", arvalid_out, 0);
        rready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            word = 64'hA000_0000_0000_0000 + 64'(k);
            driveR(1'b1, word, k == 3);
            tick();
            checkOutput("beat_rvalid", rvalid_in, 1);
            checkOutput("beat_rdata", rdata_in, {8{word}});
            checkOutput("beat_rid", rid_in, word[7:0]);
            checkOutput("beat_rresp", rresp_in, word[1:0]);
            checkOutput("beat_ruser", ruser_in, word[15:0]);
            checkOutput("beat_rlast", rlast_in, k == 3);
        end
        driveR(1'b0, 64'h0, 1'b0);
        checkOutput("single_count_before_last", rd_outstanding, 1);
        tick();
        checkOutput("single_count_end", rd_outstanding, 0);
        checkOutput("single_r_idle", rvalid_in, 0);

        // Back-pressure: downstream stalls five cycles while three ARs are offered
        arready_out = 1'b0;
        applyStimulus(1'b1, 52'h2000, 8'd0, 8'd1);
        checkOutput("bp_ready_a", arready_in, 1);
        tick();
        applyStimulus(1'b1, 52'h3000, 8'd0, 8'd2);
        checkOutput("bp_ready_b", arready_in, 1);
        tick();
        applyStimulus(1'b1, 52'h4000, 8'd0, 8'd3);
        checkOutput("bp_ready_drop", arready_in, 0);
        tick(); tick(); tick();
        checkOutput("bp_still_full", arready_in, 0);
        checkOutput("bp_hold_valid", arvalid_out, 1);
        checkOutput("bp_hold_addr", araddr_out, 52'h2000);
        arready_out = 1'b1;
        tick();
        checkOutput("bp_addr_b", araddr_out, 52'h3000);
        checkOutput("bp_ready_back", arready_in, 1);
        checkOutput("bp_count1", rd_outstanding, 1);
        tick();
        applyStimulus(1'b0, 52'h0, 8'd0, 8'd0);
        checkOutput("bp_gated", arvalid_out, 0);
        checkOutput("bp_count2", rd_outstanding, 2);
        driveR(1'b1, 64'hB0, 1'b1);
        tick();
        driveR(1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("bp_c_valid", arvalid_out, 1);
        checkOutput("bp_addr_c", araddr_out, 52'h4000);
        tick();
        checkOutput("bp_count_c", rd_outstanding, 2);
        sendRlast(2);
        checkOutput("bp_count_drained", rd_outstanding, 0);

        // Burst limit: third AR waits for the first completion
        applyStimulus(1'b1, 52'h5000, 8'd0, 8'd4);
        tick();
        applyStimulus(1'b1, 52'h6000, 8'd0, 8'd5);
        checkOutput("lim_addr_d", araddr_out, 52'h5000);
        tick();
        applyStimulus(1'b1, 52'h7000, 8'd0, 8'd6);
        checkOutput("lim_addr_e", araddr_out, 52'h6000);
        checkOutput("lim_count1", rd_outstanding, 1);
        tick();
        applyStimulus(1'b0, 52'h0, 8'd0, 8'd0);
        checkOutput("lim_gated", arvalid_out, 0);
        tick(); tick();
        checkOutput("lim_still_gated", arvalid_out, 0);
        checkOutput("lim_count2", rd_outstanding, 2);
        driveR(1'b1, 64'hC0, 1'b1);
        tick();
        driveR(1'b0, 64'h0, 1'b0);
        checkOutput("lim_gated_pre_rlast", arvalid_out, 0);
        tick();
        checkOutput("lim_f_valid", arvalid_out, 1);
        checkOutput("lim_addr_f", araddr_out, 52'h7000);
        checkOutput("lim_count_after_rlast", rd_outstanding, 1);
        tick();
        checkOutput("lim_count_f", rd_outstanding, 2);
        sendRlast(2);
        checkOutput("lim_count_drained", rd_outstanding, 0);

        // Simultaneous issue and completion at count 1
        applyStimulus(1'b1, 52'h8000, 8'd0, 8'd7);
        tick();
        applyStimulus(1'b0, 52'h0, 8'd0, 8'd0);
        tick();
        checkOutput("sim_count1", rd_outstanding, 1);
        arready_out = 1'b0;
        rready_in   = 1'b0;
        applyStimulus(1'b1, 52'h9000, 8'd0, 8'd8);
        driveR(1'b1, 64'hD0, 1'b1);
        tick();
        applyStimulus(1'b0, 52'h0, 8'd0, 8'd0);
        driveR(1'b0, 64'h0, 1'b0);
        checkOutput("sim_ar_pending", arvalid_out, 1);
        checkOutput("sim_r_pending", rvalid_in & rlast_in, 1);
        arready_out = 1'b1;
        rready_in   = 1'b1;
        tick();
        checkOutput("sim_count_same", rd_outstanding, 1);
        checkOutput("sim_ar_gone", arvalid_out, 0);
        checkOutput("sim_r_gone", rvalid_in, 0);
        sendRlast(1);
        checkOutput("sim_count_drained", rd_outstanding, 0);

        // Underflow: stray rlast is still delivered, flag sticks
        driveR(1'b1, 64'hE1, 1'b1);
        tick();
        driveR(1'b0, 64'h0, 1'b0);
        checkOutput("uf_delivered", rvalid_in, 1);
        checkOutput("uf_rdata", rdata_in, {8{64'hE1}});
        checkOutput("uf_err_before", err_underflow, 0);
        tick();
        checkOutput("uf_err_set", err_underflow, 1);
        checkOutput("uf_count_zero", rd_outstanding, 0);
        tick(); tick();
        checkOutput("uf_err_sticky", err_underflow, 1);

        // Reset in the middle of a four-beat burst
        applyStimulus(1'b1, 52'hA000, 8'd3, 8'd9);
        tick();
        applyStimulus(1'b0, 52'h0, 8'd0, 8'd0);
        tick();
        checkOutput("mr_count1", rd_outstanding, 1);
        driveR(1'b1, 64'hF10, 1'b0);
        tick();
        driveR(1'b1, 64'hF11, 1'b0);
        tick();
        checkOutput("mr_beat1", rdata_in, {8{64'hF11}});
        driveR(1'b1, 64'hF12, 1'b0);
        areset = 1'b1;
        #1;
        checkOutput("mr_rvalid_in", rvalid_in, 0);
        checkOutput("mr_arvalid_out", arvalid_out, 0);
        checkOutput("mr_arready_in", arready_in, 0);
        checkOutput("mr_rready_out", rready_out, 0);
        checkOutput("mr_count", rd_outstanding, 0);
        tick();
        checkOutput("mr_err_cleared", err_underflow, 0);
        checkOutput("mr_rvalid_held", rvalid_in, 0);
        areset = 1'b0;
        driveR(1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("mr_arready_rel", arready_in, 1);
        checkOutput("mr_rready_rel", rready_out, 1);
        checkOutput("mr_count_rel", rd_outstanding, 0);
        tick(); tick();
        checkOutput("mr_r_discarded", rvalid_in, 0);
        checkOutput("mr_ar_discarded", arvalid_out, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
